// File: rtl/xup_xor_vector_arbiter.sv
// Two-requester arbiter/sequencer for a shared combinational XOR vector: holds operands SETTLE cycles, then captures.
// Optional XUP_XOR_ARB_RR_EN selects round-robin tie-break; default is fixed priority (requester 0 wins).
module xup_xor_vector_arbiter #(
  parameter int SIZE   = 8,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  output logic [SIZE-1:0] xor_a,
  output logic [SIZE-1:0] xor_b,
  input  logic [SIZE-1:0] xor_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_data,
  output logic            busy
);
  localparam int NUM_REQ = 2;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_e;

  typedef struct packed {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
  } req_t;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ptr_q, ptr_d;
  logic [SIZE-1:0] xa_q, xa_d, xb_q, xb_d;
  logic            rv_q, rv_d;
  logic            rid_q, rid_d;
  logic [SIZE-1:0] rdata_q, rdata_d;

  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] req_rdy;
  req_t [NUM_REQ-1:0] req;
  logic               gnt_vld;
  logic               gnt_id;
  logic               idle;

  assign req_vld = {req1_valid, req0_valid};
  assign req[0]  = '{a: req0_a, b: req0_b};
  assign req[1]  = '{a: req1_a, b: req1_b};
  assign idle    = (state_q == ST_IDLE);

  // Lone requester always wins; the tie case is the only place the policy matters.
  always_comb begin
    gnt_vld = |req_vld;
    gnt_id  = req_vld[1] & ~req_vld[0];
`ifdef XUP_XOR_ARB_RR_EN
    if (&req_vld) gnt_id = ~ptr_q;
`endif
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_rdy[i] = idle & req_vld[i] & (gnt_id == 1'(i));
  end

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    xa_d    = xa_q;
    xb_d    = xb_q;
    rv_d    = rv_q;
    rid_d   = rid_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          xa_d    = req[gnt_id].a;
          xb_d    = req[gnt_id].b;
          rid_d   = gnt_id;
          ptr_d   = gnt_id;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Counter reaches 0 after SETTLE-1 decrements, so xor_y is sampled SETTLE edges after accept.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = xor_y;
          rv_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 1'b1;
      xa_q    <= '0;
      xb_q    <= '0;
      rv_q    <= 1'b0;
      rid_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      xa_q    <= xa_d;
      xb_q    <= xb_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rdata_q <= rdata_d;
    end
  end

  assign xor_a     = xa_q;
  assign xor_b     = xb_q;
  assign rsp_valid = rv_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = rdata_q;
  assign busy      = ~idle;
endmodule

// File: tb/tb_xup_xor_vector_arbiter.sv
// Scoreboard bench: timestamp-based reference model predicts handshakes; a monitor checks each response.
module tb_xup_xor_vector_arbiter;
  localparam int SZ = 8;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [SZ-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SZ-1:0] xor_a, xor_b, xor_y, rsp_data;
  logic          rsp_valid, rsp_ready, rsp_id, busy;

  xup_xor_vector_arbiter #(.SIZE(SZ), .SETTLE(ST)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // XOR vector stand-in: output is wrong until operands have been stable long enough.
  logic [SZ-1:0] pa = '0, pb = '0;
  int since = 100;
  always @(negedge clk) begin
    if (xor_a !== pa || xor_b !== pb) begin
      since <= 0;
      pa    <= xor_a;
      pb    <= xor_b;
    end else if (since < 100) begin
      since <= since + 1;
    end
  end
  assign xor_y = (since >= ST - 1) ? (xor_a ^ xor_b) : ~(xor_a ^ xor_b);

  typedef struct {
    bit            id;
    logic [SZ-1:0] data;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit            act = 0;
  int            t_acc = 0;
  bit            m_ptr = 1;
  logic [SZ-1:0] m_xa = '0, m_xb = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit pick(input bit v0, input bit v1, input bit ptr);
    if (v0 && v1) begin
`ifdef XUP_XOR_ARB_RR_EN
      return ~ptr;
`else
      return 1'b0;
`endif
    end
    return v1 && !v0;
  endfunction

  task automatic step(input bit v0, input logic [SZ-1:0] a0, input logic [SZ-1:0] b0,
                      input bit v1, input logic [SZ-1:0] a1, input logic [SZ-1:0] b1,
                      input bit rr);
    bit busy_e, rv_e, r0_e, r1_e, gid;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    busy_e = act && (cyc >= t_acc);
    rv_e   = act && (cyc >= t_acc + ST);
    r0_e = 0; r1_e = 0; gid = 0;
    if (!busy_e && (v0 || v1)) begin
      gid  = pick(v0, v1, m_ptr);
      r0_e = !gid;
      r1_e = gid;
    end
    chk("req0_ready", 32'(req0_ready), 32'(r0_e));
    chk("req1_ready", 32'(req1_ready), 32'(r1_e));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("rsp_valid", 32'(rsp_valid), 32'(rv_e));
    chk("xor_a", 32'(xor_a), 32'(m_xa));
    chk("xor_b", 32'(xor_b), 32'(m_xb));
    if (rv_e && rr) act = 0;
    if (!busy_e && (v0 || v1)) begin
      act   = 1;
      t_acc = cyc + 1;
      m_ptr = gid;
      m_xa  = gid ? a1 : a0;
      m_xb  = gid ? b1 : b0;
      q.push_back('{id: gid, data: m_xa ^ m_xb});
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 1);
  endtask

  // monitor: pops the scoreboard on every response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp @cyc %0d: got id %0d data %0h expected none", cyc, rsp_id, rsp_data);
        end else begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    reset_n = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_xor_a", 32'(xor_a), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // single request
    step(1, 8'hF0, 8'h3C, 0, '0, '0, 1);
    idle_steps(ST + 3);

    // backpressure with a competing requester held valid
    step(1, 8'h12, 8'h34, 0, '0, '0, 0);
    for (int i = 0; i < ST + 5; i++) step(0, '0, '0, 1, 8'h77, 8'h11, 0);
    for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 8'h77, 8'h11, 1);
    idle_steps(ST + 3);

    // contention
    for (int i = 0; i < 5 * (ST + 2); i++) step(1, 8'hAA, 8'h55, 1, 8'hFF, 8'h0F, 1);
    idle_steps(ST + 3);

    // reset while in SETTLE
    step(1, 8'h5A, 8'hC3, 0, '0, '0, 1);
    step(0, '0, '0, 0, '0, '0, 1);
    reset_n = 0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_xor_a", 32'(xor_a), 0);
    chk("midrst_xor_b", 32'(xor_b), 0);
    act = 0; m_ptr = 1; m_xa = '0; m_xb = '0;
    q.delete();
    @(negedge clk);
    reset_n = 1;
    idle_steps(ST + 4);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), SZ'($urandom), SZ'($urandom),
           1'($urandom_range(0, 1)), SZ'($urandom), SZ'($urandom),
           $urandom_range(0, 3) != 0);
    idle_steps(ST + 4);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
